// File: rtl/i2c_init_seq.sv
// i2c_init_seq: table-driven I2C init sequencer. start->i2c_start 1 cycle, final ready rise->done 1 cycle.
// Stalls in WAIT while i2c_ready is low. Define I2C_INIT_SEQ_ABORT_EN to end the sequence on the first nack.
module i2c_init_seq #(
  parameter int unsigned               NUM_BYTES  = 2,
  parameter logic [6:0]                I2C_ADDR   = 7'h21,
  parameter logic [8*NUM_BYTES-1:0]    INIT_DATA  = 16'hBBAA,
  parameter int unsigned               GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] progress,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_data,
  output logic       i2c_start,
  input  logic       i2c_ready,
  input  logic       i2c_nack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [7:0]  LAST_IDX = 8'(NUM_BYTES - 1);
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  progress_nxt;
  logic [7:0]  data_nxt;
  logic        start_nxt;
  logic        busy_nxt;
  logic        done_nxt;
  logic        error_nxt;
  logic [15:0] gap_cnt, gap_nxt;
  logic        abort_hit;

  // A shift keeps the table lookup free of index-width mismatches for any NUM_BYTES.
  function automatic logic [7:0] byte_at(input logic [7:0] idx);
    logic [8*NUM_BYTES-1:0] sh;
    sh = INIT_DATA >> {idx, 3'b000};
    return sh[7:0];
  endfunction

`ifdef I2C_INIT_SEQ_ABORT_EN
  assign abort_hit = i2c_nack;
`else
  assign abort_hit = 1'b0;
`endif

  assign i2c_addr = I2C_ADDR;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      progress  <= 8'd0;
      i2c_data  <= 8'd0;
      i2c_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      gap_cnt   <= 16'd0;
    end else begin
      state     <= state_nxt;
      progress  <= progress_nxt;
      i2c_data  <= data_nxt;
      i2c_start <= start_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      error     <= error_nxt;
      gap_cnt   <= gap_nxt;
    end
  end

  // i2c_start/i2c_data are loaded on the transition into ISSUE so the request
  // appears one cycle after the decision, not two.
  always_comb begin
    state_nxt    = state;
    progress_nxt = progress;
    data_nxt     = i2c_data;
    start_nxt    = i2c_start;
    busy_nxt     = busy;
    done_nxt     = done;
    error_nxt    = error;
    gap_nxt      = gap_cnt;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt    = S_ISSUE;
          progress_nxt = 8'd0;
          error_nxt    = 1'b0;
          busy_nxt     = 1'b1;
          data_nxt     = byte_at(8'd0);
          start_nxt    = 1'b1;
        end
      end

      S_ISSUE: begin
        data_nxt  = byte_at(progress);
        start_nxt = 1'b1;
        if (!i2c_ready) begin
          state_nxt = S_WAIT;
          start_nxt = 1'b0;
        end
      end

      S_WAIT: begin
        if (i2c_ready) begin
          error_nxt = error | i2c_nack;
          if (progress == LAST_IDX || abort_hit) begin
            state_nxt = S_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            progress_nxt = progress + 8'd1;
            if (GAP_CYCLES == 0) begin
              state_nxt = S_ISSUE;
              start_nxt = 1'b1;
              data_nxt  = byte_at(progress + 8'd1);
            end else begin
              state_nxt = S_GAP;
              gap_nxt   = GAP_LOAD;
            end
          end
        end
      end

      S_GAP: begin
        if (gap_cnt == 16'd0) begin
          state_nxt = S_ISSUE;
          start_nxt = 1'b1;
          data_nxt  = byte_at(progress);
        end else begin
          gap_nxt = gap_cnt - 16'd1;
        end
      end

      S_DONE: begin
        if (!start) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b0;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_init_seq.sv
// Scoreboarded bench for i2c_init_seq: three instances (defaults, 4 bytes with gap 5, 3 bytes) with a modelled master each.
module tb_i2c_init_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [2:0]      start, busy, done, error, istart, rdy, nack;
  logic [2:0][7:0] prog, dat;
  logic [2:0][6:0] adr;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         inst;
    logic [7:0] dat;
  } exp_t;
  exp_t exp_q[$];
  int   sent_cnt[3] = '{default: 0};

  logic [2:0]      early, nack_en;
  logic [2:0][7:0] nack_val, cur;
  logic [2:0]      mbusy;
  int              mcnt[3];

  i2c_init_seq u_def (
    .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .error(error[0]), .progress(prog[0]), .i2c_addr(adr[0]), .i2c_data(dat[0]),
    .i2c_start(istart[0]), .i2c_ready(rdy[0]), .i2c_nack(nack[0])
  );

  i2c_init_seq #(.NUM_BYTES(4), .INIT_DATA(32'h44332211), .GAP_CYCLES(5)) u_gap (
    .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .error(error[1]), .progress(prog[1]), .i2c_addr(adr[1]), .i2c_data(dat[1]),
    .i2c_start(istart[1]), .i2c_ready(rdy[1]), .i2c_nack(nack[1])
  );

  i2c_init_seq #(.NUM_BYTES(3), .INIT_DATA(24'h332211)) u_three (
    .clk(clk), .reset(reset), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .error(error[2]), .progress(prog[2]), .i2c_addr(adr[2]), .i2c_data(dat[2]),
    .i2c_start(istart[2]), .i2c_ready(rdy[2]), .i2c_nack(nack[2])
  );

  // Master model: goes busy the cycle after it sees i2c_start, ready again 10 cycles later.
  // In early mode ready idles low, so every ISSUE is entered with ready already low.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        rdy[i]   <= ~early[i];
        nack[i]  <= 1'b0;
        mbusy[i] <= 1'b0;
        mcnt[i]  <= 0;
      end else begin
        nack[i] <= 1'b0;
        if (mbusy[i]) begin
          if (mcnt[i] == 0) begin
            rdy[i]   <= 1'b1;
            nack[i]  <= nack_en[i] && (cur[i] == nack_val[i]);
            mbusy[i] <= 1'b0;
          end else begin
            mcnt[i] <= mcnt[i] - 1;
          end
        end else if (istart[i] && (rdy[i] || early[i])) begin
          rdy[i]   <= 1'b0;
          mbusy[i] <= 1'b1;
          mcnt[i]  <= 9;
          cur[i]   <= dat[i];
        end else if (early[i]) begin
          rdy[i] <= 1'b0;
        end
      end
    end
  end

  function automatic logic [7:0] byte_of(input int i, input int k);
    if (i == 0) return (k == 0) ? 8'hAA : 8'hBB;
    return 8'((k + 1) * 17);
  endfunction

  task automatic push_seq(input int i, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.inst = i;
      e.dat  = byte_of(i, k);
      exp_q.push_back(e);
    end
  endtask

  // Pops the scoreboard on every i2c_start rise and checks request timing.
  task automatic monitor();
    logic [2:0] p_st, p_rdy, p_busy, p_done;
    int         rise_c[3];
    int         last_rdy[3];
    int         lat;
    int         wid;
    exp_t       e;
    p_st = '0; p_rdy = '0; p_busy = '0; p_done = '0;
    rise_c = '{default: 0};
    last_rdy = '{default: 0};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (busy[i] === 1'b1 && p_busy[i] !== 1'b1) sent_cnt[i] = 0;
        if (rdy[i] === 1'b1 && p_rdy[i] !== 1'b1) last_rdy[i] = cyc;
        if (istart[i] === 1'b1 && p_st[i] !== 1'b1) begin
          rise_c[i] = cyc;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL byte_order inst%0d: unexpected byte %h, required none", i, dat[i]);
          end else begin
            e = exp_q.pop_front();
            if (e.inst != i || e.dat !== dat[i]) begin
              n_fail++;
              $display("FAIL byte_order inst%0d: actual %h, required %h (inst%0d)", i, dat[i], e.dat, e.inst);
            end
          end
          n_checks++;
          if (adr[i] !== 7'h21) begin
            n_fail++;
            $display("FAIL i2c_addr inst%0d: actual %h, required 21", i, adr[i]);
          end
          n_checks++;
          if (prog[i] !== 8'(sent_cnt[i])) begin
            n_fail++;
            $display("FAIL progress inst%0d: actual %0d, required %0d", i, prog[i], sent_cnt[i]);
          end
          if (sent_cnt[i] > 0) begin
            lat = (i == 1) ? 6 : 1;
            n_checks++;
            if (cyc - last_rdy[i] != lat) begin
              n_fail++;
              $display("FAIL gap inst%0d: ready-rise to i2c_start %0d cycles, required %0d", i, cyc - last_rdy[i], lat);
            end
          end
          sent_cnt[i]++;
        end
        if (istart[i] === 1'b0 && p_st[i] === 1'b1) begin
          wid = early[i] ? 1 : 2;
          n_checks++;
          if (cyc - rise_c[i] != wid) begin
            n_fail++;
            $display("FAIL start_width inst%0d: actual %0d, required %0d", i, cyc - rise_c[i], wid);
          end
        end
        if (done[i] === 1'b1 && p_done[i] !== 1'b1) begin
          n_checks++;
          if (cyc - last_rdy[i] != 1) begin
            n_fail++;
            $display("FAIL done_latency inst%0d: actual %0d, required 1", i, cyc - last_rdy[i]);
          end
        end
        p_st[i]   = istart[i];
        p_rdy[i]  = rdy[i];
        p_busy[i] = busy[i];
        p_done[i] = done[i];
      end
    end
  endtask

  task automatic wait_done(input int i, input string name);
    int k;
    k = 0;
    while (done[i] !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (done[i] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: done actual %b after %0d cycles, required 1", name, done[i], k);
    end
  endtask

  task automatic kick(input int i, input string name);
    start[i] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (istart[i] !== 1'b1 || busy[i] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start_latency: i2c_start %b busy %b, required 1 1", name, istart[i], busy[i]);
    end
  endtask

  task automatic check_end(input int i, input string name, input logic err, input logic [7:0] p,
                           input int nsent);
    n_checks++;
    if (error[i] !== err || busy[i] !== 1'b0 || prog[i] !== p || dat[i] !== byte_of(i, int'(p))) begin
      n_fail++;
      $display("FAIL %s status: error %b busy %b progress %0d data %h, required %b 0 %0d %h",
               name, error[i], busy[i], prog[i], dat[i], err, p, byte_of(i, int'(p)));
    end
    n_checks++;
    if (sent_cnt[i] != nsent || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s count: sent %0d pending %0d, required %0d 0", name, sent_cnt[i], exp_q.size(), nsent);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = '0; early = '0; nack_en = '0; nack_val = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (busy[i] !== 1'b0 || done[i] !== 1'b0 || error[i] !== 1'b0 || istart[i] !== 1'b0 ||
          prog[i] !== 8'd0 || dat[i] !== 8'd0 || adr[i] !== 7'h21) begin
        n_fail++;
        $display("FAIL reset inst%0d: busy %b done %b error %b start %b prog %h data %h addr %h, required 0 0 0 0 00 00 21",
                 i, busy[i], done[i], error[i], istart[i], prog[i], dat[i], adr[i]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    push_seq(0, 2);
    kick(0, "basic");
    wait_done(0, "basic");
    check_end(0, "basic", 1'b0, 8'd1, 2);
    repeat (20) @(negedge clk);
    n_checks++;
    if (done[0] !== 1'b1 || busy[0] !== 1'b0 || sent_cnt[0] != 2) begin
      n_fail++;
      $display("FAIL basic_hold: done %b busy %b sent %0d, required 1 0 2", done[0], busy[0], sent_cnt[0]);
    end
    start[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_drop: done %b, required 0", done[0]);
    end
  endtask

  task automatic test_gap();
    push_seq(1, 4);
    kick(1, "gap");
    wait_done(1, "gap");
    check_end(1, "gap", 1'b0, 8'd3, 4);
    start[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nack();
    nack_en[2]  = 1'b1;
    nack_val[2] = 8'h22;
`ifdef I2C_INIT_SEQ_ABORT_EN
    push_seq(2, 2);
    kick(2, "nack");
    wait_done(2, "nack");
    check_end(2, "nack", 1'b1, 8'd1, 2);
`else
    push_seq(2, 3);
    kick(2, "nack");
    wait_done(2, "nack");
    check_end(2, "nack", 1'b1, 8'd2, 3);
`endif
  endtask

  task automatic test_hold_retrigger();
    int s0;
    s0 = sent_cnt[2];
    nack_en[2] = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (done[2] !== 1'b1 || busy[2] !== 1'b0 || error[2] !== 1'b1 || sent_cnt[2] != s0) begin
      n_fail++;
      $display("FAIL hold_no_retrigger: done %b busy %b error %b sent %0d, required 1 0 1 %0d",
               done[2], busy[2], error[2], sent_cnt[2], s0);
    end
    start[2] = 1'b0;
    repeat (2) @(negedge clk);
    push_seq(2, 3);
    kick(2, "retrigger");
    n_checks++;
    if (error[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL retrigger_error_clear: error %b, required 0", error[2]);
    end
    wait_done(2, "retrigger");
    check_end(2, "retrigger", 1'b0, 8'd2, 3);
    start[2] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int k;
    push_seq(1, 4);
    kick(1, "reset_mid");
    k = 0;
    while (!(sent_cnt[1] == 2 && istart[1] === 1'b0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (sent_cnt[1] != 2 || busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_reach: sent %0d busy %b, required 2 1", sent_cnt[1], busy[1]);
    end
    reset = 1'b1;
    start[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (istart[1] !== 1'b0 || busy[1] !== 1'b0 || prog[1] !== 8'd0 || done[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_state: start %b busy %b prog %0d done %b, required 0 0 0 0",
               istart[1], busy[1], prog[1], done[1]);
    end
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    push_seq(1, 4);
    kick(1, "reset_mid_rerun");
    wait_done(1, "reset_mid_rerun");
    check_end(1, "reset_mid_rerun", 1'b0, 8'd3, 4);
    start[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_early_ready_low();
    early[0] = 1'b1;
    repeat (3) @(negedge clk);
    push_seq(0, 2);
    kick(0, "early");
    wait_done(0, "early");
    check_end(0, "early", 1'b0, 8'd1, 2);
    start[0] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_gap();
    test_nack();
    test_hold_retrigger();
    test_reset_mid();
    test_early_ready_low();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
